// File: rtl/irq_controller.sv
// Interrupt controller: latches device requests, applies mask and edge/level mode,
// picks one source by fixed priority and runs a request/ack/EOI handshake with the CPU.
module irq_controller #(
   parameter int N_SRC = 6,
   parameter int ID_W  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_SRC-1:0] irq_src,
   input  logic [1:0]       dev_addr,
   input  logic [31:0]      dev_write_data,
   input  logic             dev_write_en,
   output logic [31:0]      dev_read_data,
   output logic             int_out,
   output logic [ID_W-1:0]  int_id,
   input  logic             int_ack
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t             state_q, state_d;
   logic [N_SRC-1:0]   mode_q, mask_q, edge_q, prev_src_q;
   logic [N_SRC-1:0]   rise, pend, eligible, id_oh, ack_clr, clr, edge_d;
   logic [N_SRC-1:0]   wdata;
   logic [ID_W-1:0]    sel, in_service_id, int_id_d, in_service_id_d;
   logic               in_service_valid, in_service_valid_d, int_out_d;
   logic               wr_mode, wr_mask, wr_pend, wr_stat, eoi, withdrawn;
   logic [2:0]         isid3;
   logic               unused_wdata;

   assign wdata        = dev_write_data[N_SRC-1:0];
   assign unused_wdata = ^dev_write_data;
   assign wr_mode      = dev_write_en && (dev_addr == 2'd0);
   assign wr_mask      = dev_write_en && (dev_addr == 2'd1);
   assign wr_pend      = dev_write_en && (dev_addr == 2'd2);
   assign wr_stat      = dev_write_en && (dev_addr == 2'd3);
   assign eoi          = wr_stat && (state_q == SERVICE);

   assign rise     = irq_src & ~prev_src_q;
   assign pend     = (mode_q & edge_q) | (~mode_q & irq_src);
   assign eligible = pend & mask_q;

   always_comb begin
      sel   = '0;
      id_oh = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) sel = ID_W'(i);
      end
      for (int i = 0; i < N_SRC; i++) begin
         id_oh[i] = (int_id == ID_W'(i));
      end
   end

   assign withdrawn = ~|(eligible & id_oh);

   // A new rising edge always beats any clear in the same cycle.
   assign clr    = (wr_pend ? wdata : '0) | (wr_mode ? (wdata ^ mode_q) : '0) | ack_clr;
   assign edge_d = (edge_q & ~clr) | (rise & mode_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         int_out          <= 1'b0;
         int_id           <= '0;
         in_service_valid <= 1'b0;
         in_service_id    <= '0;
         mode_q           <= '0;
         mask_q           <= '0;
         edge_q           <= '0;
         prev_src_q       <= '0;
      end else begin
         state_q          <= state_d;
         int_out          <= int_out_d;
         int_id           <= int_id_d;
         in_service_valid <= in_service_valid_d;
         in_service_id    <= in_service_id_d;
         edge_q           <= edge_d;
         prev_src_q       <= irq_src;
         if (wr_mode) mode_q <= wdata;
         if (wr_mask) mask_q <= wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|eligible) state_d = REQ;
         REQ: begin
            if (int_ack)        state_d = SERVICE;
            else if (withdrawn) state_d = IDLE;
         end
         SERVICE: if (eoi) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // int_id stays frozen while in REQ; only IDLE re-arbitrates.
   always_comb begin
      int_out_d          = int_out;
      int_id_d           = int_id;
      in_service_valid_d = in_service_valid;
      in_service_id_d    = in_service_id;
      ack_clr            = '0;
      case (state_q)
         IDLE: begin
            int_out_d = 1'b0;
            if (|eligible) begin
               int_out_d = 1'b1;
               int_id_d  = sel;
            end
         end
         REQ: begin
            if (int_ack) begin
               int_out_d          = 1'b0;
               in_service_valid_d = 1'b1;
               in_service_id_d    = int_id;
               ack_clr            = id_oh;
            end else if (withdrawn) begin
               int_out_d = 1'b0;
            end
         end
         SERVICE: begin
            int_out_d = 1'b0;
            if (eoi) in_service_valid_d = 1'b0;
         end
         default: int_out_d = 1'b0;
      endcase
   end

   assign isid3 = 3'(in_service_id);

   always_comb begin
      dev_read_data = '0;
      case (dev_addr)
         2'd0: dev_read_data = 32'(mode_q);
         2'd1: dev_read_data = 32'(mask_q);
         2'd2: dev_read_data = 32'(pend);
         2'd3: dev_read_data = {28'b0, in_service_valid, isid3};
         default: dev_read_data = '0;
      endcase
   end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: a priority vector table fed through a
// scoreboard queue, then hand-written sequences for the handshake corner cases.
module tb_irq_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  irq_src;
   logic [1:0]  dev_addr;
   logic [31:0] dev_write_data;
   logic        dev_write_en;
   logic [31:0] dev_read_data;
   logic        int_out;
   logic [2:0]  int_id;
   logic        int_ack;

   int checks = 0;
   int errors = 0;

   irq_controller #(.N_SRC(6), .ID_W(3)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .irq_src        (irq_src),
      .dev_addr       (dev_addr),
      .dev_write_data (dev_write_data),
      .dev_write_en   (dev_write_en),
      .dev_read_data  (dev_read_data),
      .int_out        (int_out),
      .int_id         (int_id),
      .int_ack        (int_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] src;
      logic [5:0] mask;
      logic       exp_out;
      logic       chk_id;
      logic [2:0] exp_id;
   } vec_t;

   typedef struct {
      logic       exp_out;
      logic       chk_id;
      logic [2:0] exp_id;
   } exp_t;

   vec_t vecs[8];
   exp_t sb_q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
      dev_addr       = a;
      dev_write_data = d;
      dev_write_en   = 1'b1;
      tick();
      dev_write_en   = 1'b0;
      dev_write_data = '0;
   endtask

   task automatic reg_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
      dev_addr = a;
      #1;
      chk(name, dev_read_data, exp);
   endtask

   task automatic ack_pulse();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
   endtask

   initial begin
      exp_t e;
      rst_n = 1'b0; irq_src = '0; dev_addr = '0; dev_write_data = '0;
      dev_write_en = 1'b0; int_ack = 1'b0;

      vecs[0] = '{src: 6'h04, mask: 6'h04, exp_out: 1'b1, chk_id: 1'b1, exp_id: 3'd2};
      vecs[1] = '{src: 6'h3F, mask: 6'h3F, exp_out: 1'b1, chk_id: 1'b1, exp_id: 3'd0};
      vecs[2] = '{src: 6'h30, mask: 6'h3F, exp_out: 1'b1, chk_id: 1'b1, exp_id: 3'd4};
      vecs[3] = '{src: 6'h3E, mask: 6'h38, exp_out: 1'b1, chk_id: 1'b1, exp_id: 3'd3};
      vecs[4] = '{src: 6'h0F, mask: 6'h30, exp_out: 1'b0, chk_id: 1'b0, exp_id: 3'd0};
      vecs[5] = '{src: 6'h20, mask: 6'h20, exp_out: 1'b1, chk_id: 1'b1, exp_id: 3'd5};
      vecs[6] = '{src: 6'h21, mask: 6'h3E, exp_out: 1'b1, chk_id: 1'b1, exp_id: 3'd5};
      vecs[7] = '{src: 6'h22, mask: 6'h3F, exp_out: 1'b1, chk_id: 1'b1, exp_id: 3'd1};

      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("reset_int_out", 32'(int_out), 32'd0);
      chk("reset_int_id", 32'(int_id), 32'd0);
      reg_chk("reset_mode", 2'd0, 32'h0);
      reg_chk("reset_mask", 2'd1, 32'h0);
      reg_chk("reset_stat", 2'd3, 32'h0);

      // Level-mode priority table through the scoreboard
      for (int i = 0; i < 8; i++) begin
         irq_src = vecs[i].src;
         sb_q.push_back('{exp_out: vecs[i].exp_out, chk_id: vecs[i].chk_id, exp_id: vecs[i].exp_id});
         reg_write(2'd1, 32'(vecs[i].mask));
         tick();
         if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk($sformatf("vec%0d_int_out", i), 32'(int_out), 32'(e.exp_out));
            if (e.chk_id) chk($sformatf("vec%0d_int_id", i), 32'(int_id), 32'(e.exp_id));
         end
         irq_src = '0;
         reg_write(2'd1, 32'h0);
         tick();
         chk($sformatf("vec%0d_cleared", i), 32'(int_out), 32'd0);
      end
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      // Level request, ack, EOI with the source still asserted
      irq_src = 6'h04;
      reg_write(2'd1, 32'h04);
      chk("lvl_not_yet", 32'(int_out), 32'd0);
      tick();
      chk("lvl_int_out", 32'(int_out), 32'd1);
      chk("lvl_int_id", 32'(int_id), 32'd2);
      ack_pulse();
      chk("lvl_ack_out", 32'(int_out), 32'd0);
      reg_chk("lvl_stat", 2'd3, 32'h0A);
      reg_write(2'd3, 32'h0);
      chk("lvl_eoi_out", 32'(int_out), 32'd0);
      reg_chk("lvl_eoi_stat", 2'd3, 32'h02);
      tick();
      chk("lvl_rearm_out", 32'(int_out), 32'd1);
      irq_src = '0;
      tick();
      chk("lvl_drop_out", 32'(int_out), 32'd0);
      reg_write(2'd1, 32'h0);

      // Edge mode with simultaneous pulses
      reg_write(2'd0, 32'h3F);
      reg_write(2'd1, 32'h3F);
      irq_src = 6'h22;
      tick();
      irq_src = '0;
      reg_chk("edge_pend", 2'd2, 32'h22);
      tick();
      chk("edge_out1", 32'(int_out), 32'd1);
      chk("edge_id1", 32'(int_id), 32'd1);
      ack_pulse();
      reg_chk("edge_pend_after_ack", 2'd2, 32'h20);
      reg_chk("edge_stat1", 2'd3, 32'h09);
      reg_write(2'd3, 32'h0);
      tick();
      chk("edge_out5", 32'(int_out), 32'd1);
      chk("edge_id5", 32'(int_id), 32'd5);
      ack_pulse();
      reg_write(2'd3, 32'h0);
      tick();
      chk("edge_done_out", 32'(int_out), 32'd0);
      reg_chk("edge_done_pend", 2'd2, 32'h00);
      tick();
      chk("edge_quiet_out", 32'(int_out), 32'd0);

      // Withdrawal before ack
      reg_write(2'd0, 32'h0);
      irq_src = 6'h08;
      reg_write(2'd1, 32'h08);
      tick();
      chk("wd_out", 32'(int_out), 32'd1);
      chk("wd_id", 32'(int_id), 32'd3);
      irq_src = '0;
      tick();
      chk("wd_dropped", 32'(int_out), 32'd0);
      ack_pulse();
      chk("wd_late_ack_out", 32'(int_out), 32'd0);
      reg_chk("wd_late_ack_stat", 2'd3, 32'h05);

      // Set/clear collisions on the source 0 edge flag
      reg_write(2'd0, 32'h01);
      reg_write(2'd1, 32'h01);
      irq_src = 6'h01;
      tick();
      irq_src = '0;
      tick();
      chk("col_out", 32'(int_out), 32'd1);
      chk("col_id", 32'(int_id), 32'd0);
      irq_src = 6'h01;
      ack_pulse();
      irq_src = '0;
      reg_chk("col_ack_pend", 2'd2, 32'h01);
      reg_chk("col_ack_stat", 2'd3, 32'h08);
      tick();
      irq_src = 6'h01;
      reg_write(2'd2, 32'h01);
      reg_chk("col_w1c_pend", 2'd2, 32'h01);
      reg_write(2'd2, 32'h01);
      reg_chk("w1c_clears", 2'd2, 32'h00);
      irq_src = '0;
      reg_write(2'd3, 32'h0);
      reg_chk("col_eoi_stat", 2'd3, 32'h00);

      // Stray EOI / ack, then masking during a request
      reg_write(2'd3, 32'h0);
      reg_chk("stray_eoi_stat", 2'd3, 32'h00);
      chk("stray_eoi_out", 32'(int_out), 32'd0);
      reg_write(2'd0, 32'h0);
      irq_src = 6'h10;
      reg_write(2'd1, 32'h10);
      tick();
      chk("st_req_id", 32'(int_id), 32'd4);
      ack_pulse();
      reg_chk("st_svc_stat", 2'd3, 32'h0C);
      ack_pulse();
      reg_chk("st_stray_ack_stat", 2'd3, 32'h0C);
      chk("st_stray_ack_out", 32'(int_out), 32'd0);
      reg_write(2'd3, 32'h0);
      tick();
      chk("st_rearm_out", 32'(int_out), 32'd1);
      reg_write(2'd1, 32'h0);
      tick();
      chk("st_mask_all_out", 32'(int_out), 32'd0);
      ack_pulse();
      reg_chk("st_ignored_ack_stat", 2'd3, 32'h04);
      irq_src = '0;

      // Asynchronous reset in the middle of SERVICE
      reg_write(2'd0, 32'h3F);
      reg_write(2'd1, 32'h3F);
      irq_src = 6'h06;
      tick();
      irq_src = '0;
      tick();
      chk("rst_pre_id", 32'(int_id), 32'd1);
      ack_pulse();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_int_out", 32'(int_out), 32'd0);
      chk("rst_int_id", 32'(int_id), 32'd0);
      reg_chk("rst_stat", 2'd3, 32'h0);
      reg_chk("rst_mask", 2'd1, 32'h0);
      reg_chk("rst_pend", 2'd2, 32'h0);
      rst_n = 1'b1;
      tick();
      chk("rst_after_out", 32'(int_out), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
